hazard_scoreboard: RTL and testbench

Parametrised hazard controller for the in-order RISC-V pipeline, generalising load-use detection to any number of variable-latency producers (loads with slow memory, multi-cycle mul/div). A per-register countdown scoreboard, updated at issue from ID, drives the ID-stage `stall` for RAW and WAW conflicts. Taken branches resolved in EX drive `flush`. It replaces the single-cycle load-use check and sits beside the decoder, feeding the IF/ID and ID/EX pipeline-register enables.

---
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard driving ID-stage stall
// for RAW/WAW conflicts against variable-latency producers, plus EX-resolved
// branch flush. Optional `HAZARD_PERF_EN adds stall/flush event counters.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LAT_W    = 3,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs1_addr,
  input  logic [AW-1:0]       id_rs2_addr,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [AW-1:0]       id_rd_addr,
  input  logic                id_rd_we,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                ex_pcsrc,
  output logic                stall,
  output logic                flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flush_count
`endif
);

  // x0 is hard-wired zero, so only registers 1..NUM_REGS-1 carry a countdown
  logic [LAT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_d [1:NUM_REGS-1];

  logic rs1_conf;
  logic rs2_conf;
  logic waw_conf;
  logic issue;

  // Pending mask straight from the registered counters
  always_comb begin
    pending = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
  end

  assign busy = |pending;

  // Conflict detection uses pre-issue state, so an instruction never sees its own write
  always_comb begin
    rs1_conf = id_rs1_used && (id_rs1_addr != '0) && pending[id_rs1_addr];
    rs2_conf = id_rs2_used && (id_rs2_addr != '0) && pending[id_rs2_addr];
    waw_conf = id_rd_we    && (id_rd_addr  != '0) && pending[id_rd_addr];
  end

  // Redirect has priority: a flush cycle never reports stall and never issues
  always_comb begin
    flush = ex_pcsrc;
    stall = id_valid && !flush && (rs1_conf || rs2_conf || waw_conf);
    issue = id_valid && !stall && !flush;
  end

  // Next countdown: load on issue of a slow producer, else count down to zero
  always_comb begin
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue && id_rd_we && (id_rd_addr == AW'(r)) && (id_lat != '0)) begin
        cnt_d[r] = id_lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
  end

  // Countdown registers; reset discards every outstanding entry
  always_ff @(posedge clk) begin
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall) perf_stall_q <= perf_stall_q + 32'(1);
      if (flush) perf_flush_q <= perf_flush_q + 32'(1);
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-cycle vector table with expected outputs
// queued at drive time, plus a latency/distance sweep of stall lengths.
module tb_hazard_scoreboard;

  localparam int unsigned NR = 32;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic          id_rs1_used, id_rs2_used, id_rd_we;
  logic [LW-1:0] id_lat;
  logic          ex_pcsrc;
  logic          stall, flush, busy;
  logic [NR-1:0] pending;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.NUM_REGS(NR), .LAT_W(LW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .ex_pcsrc(ex_pcsrc), .stall(stall), .flush(flush),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, vld;
    logic [4:0]    rs1; logic u1;
    logic [4:0]    rs2; logic u2;
    logic [4:0]    rd;  logic we;
    logic [LW-1:0] lat;
    logic          pc;
    logic          e_stall, e_flush;
    logic [NR-1:0] e_pend;
  } vec_t;

  typedef struct {
    logic          e_stall, e_flush, e_busy;
    logic [NR-1:0] e_pend;
    int            idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic v,
                              input int rs1, input logic u1,
                              input int rs2, input logic u2,
                              input int rd, input logic we, input int lat,
                              input logic pc, input logic es, input logic ef,
                              input logic [NR-1:0] ep);
    vec_t t;
    t.rst = r; t.vld = v;
    t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
    t.rd = 5'(rd); t.we = we; t.lat = LW'(lat); t.pc = pc;
    t.e_stall = es; t.e_flush = ef; t.e_pend = ep;
    return t;
  endfunction

  function automatic logic [NR-1:0] b(input int r);
    return NR'(1) << r;
  endfunction

  function automatic vec_t idle(input logic [NR-1:0] ep);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep);
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; id_valid = v.vld;
    id_rs1_addr = v.rs1; id_rs1_used = v.u1;
    id_rs2_addr = v.rs2; id_rs2_used = v.u2;
    id_rd_addr = v.rd; id_rd_we = v.we; id_lat = v.lat; ex_pcsrc = v.pc;
  endtask

  task automatic cmp(input string nm, input logic [NR-1:0] act, input logic [NR-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one vector at negedge, queue its expectation, check #1 later
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    drive(v);
    e.e_stall = v.e_stall; e.e_flush = v.e_flush;
    e.e_pend = v.e_pend; e.e_busy = |v.e_pend; e.idx = idx;
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    cmp($sformatf("vec%0d stall", g.idx), NR'(stall), NR'(g.e_stall));
    cmp($sformatf("vec%0d flush", g.idx), NR'(flush), NR'(g.e_flush));
    cmp($sformatf("vec%0d pending", g.idx), pending, g.e_pend);
    cmp($sformatf("vec%0d busy", g.idx), NR'(busy), NR'(g.e_busy));
  endtask

  initial begin
    int nstall;
    drive(idle('0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    vecs.push_back(idle('0));
    // load x5 lat1, then add x6,x5,x7
    vecs.push_back(mk(0,1, 0,0, 0,0, 5,1,1, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 5,1, 7,1, 6,1,0, 0, 1,0, b(5)));
    vecs.push_back(mk(0,1, 5,1, 7,1, 6,1,0, 0, 0,0, '0));
    vecs.push_back(idle('0));
    // div x3 lat4, nop, sub x4,x3,x3
    vecs.push_back(mk(0,1, 0,0, 0,0, 3,1,4, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0, 0,0, b(3)));
    vecs.push_back(mk(0,1, 3,1, 3,1, 4,1,0, 0, 1,0, b(3)));
    vecs.push_back(mk(0,1, 3,1, 3,1, 4,1,0, 0, 1,0, b(3)));
    vecs.push_back(mk(0,1, 3,1, 3,1, 4,1,0, 0, 1,0, b(3)));
    vecs.push_back(mk(0,1, 3,1, 3,1, 4,1,0, 0, 0,0, '0));
    // producer to x0 with lat5, then consumer of x0
    vecs.push_back(mk(0,1, 0,0, 0,0, 0,1,5, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 0,1, 0,1, 1,1,0, 0, 0,0, '0));
    // div x8 lat4, then addi x8,x1,1 (WAW)
    vecs.push_back(mk(0,1, 0,0, 0,0, 8,1,4, 0, 0,0, '0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1, 1,1, 0,0, 8,1,0, 0, 1,0, b(8)));
    vecs.push_back(mk(0,1, 1,1, 0,0, 8,1,0, 0, 0,0, '0));
    // load x10 lat2, dependent flushed, countdown continues
    vecs.push_back(mk(0,1, 0,0, 0,0, 10,1,2, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 10,1, 0,0, 11,1,1, 1, 0,1, b(10)));
    vecs.push_back(mk(0,1, 10,1, 0,0, 11,1,1, 0, 1,0, b(10)));
    vecs.push_back(mk(0,1, 10,1, 0,0, 11,1,1, 0, 0,0, '0));
    vecs.push_back(idle(b(11)));
    vecs.push_back(idle('0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 0,1, '0));
    // cnt[9]=3 then reset pulse
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,3, 0, 0,0, '0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0, 0,0, b(9)));
    vecs.push_back(mk(0,1, 9,1, 9,1, 12,1,0, 0, 0,0, '0));
    // lw x1,0(x1) twice: no self-stall, second waits on the first
    vecs.push_back(mk(0,1, 1,1, 0,0, 1,1,1, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 1,1, 0,0, 1,1,1, 0, 1,0, b(1)));
    vecs.push_back(mk(0,1, 1,1, 0,0, 1,1,1, 0, 0,0, '0));
    vecs.push_back(idle(b(1)));
    vecs.push_back(idle('0));
    // unused source ignored; rs2-only conflict stalls
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 7,0, 2,1, 0,0,0, 0, 0,0, b(7)));
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,2, 0, 0,0, '0));
    vecs.push_back(mk(0,1, 2,1, 7,1, 0,0,0, 0, 1,0, b(7)));
    vecs.push_back(mk(0,1, 2,1, 7,1, 0,0,0, 0, 1,0, b(7)));
    vecs.push_back(mk(0,1, 2,1, 7,1, 0,0,0, 0, 0,0, '0));
    // invalid ID slot never stalls
    vecs.push_back(mk(0,1, 0,0, 0,0, 13,1,1, 0, 0,0, '0));
    vecs.push_back(mk(0,0, 13,1, 13,1, 13,1,0, 0, 0,0, b(13)));
    vecs.push_back(idle('0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Sweep latency L and distance k: stall length must be max(0, L-k+1)
    for (int lat = 1; lat <= 7; lat++) begin
      for (int k = 1; k <= lat + 2; k++) begin
        @(negedge clk);
        drive(mk(0,1, 0,0, 0,0, 20,1,lat, 0, 0,0, '0));
        for (int j = 1; j < k; j++) begin
          @(negedge clk);
          drive(idle('0));
        end
        nstall = 0;
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          drive(mk(0,1, 20,1, 0,0, 21,1,0, 0, 0,0, '0));
          #1;
          if (!stall) break;
          nstall++;
        end
        cmp($sformatf("sweep L%0d k%0d stall_cycles", lat, k), NR'(nstall),
            NR'((lat - k + 1 > 0) ? lat - k + 1 : 0));
        @(negedge clk);
        drive(idle('0));
        #1;
        cmp($sformatf("sweep L%0d k%0d drained", lat, k), pending, '0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
